// File: rtl/kyber_link_buffer.sv
// kyber_link_buffer: store-and-forward frame buffer for the Kyber word link.
// Captures one pk/ct frame, flags it ready, replays it on matching request.
// Ports: clk, rst (async active-low), start/k/msg_type (frame setup),
//   wen/din (input words), req_pk/req_c (drain requests),
//   ready_pk/ready_c (frame held), valid/dout (output words),
//   err (sticky error), busy (not IDLE).
module kyber_link_buffer #(
  parameter int DEPTH = 512,
  parameter int AW    = 9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  k,
  input  logic        msg_type,
  input  logic        wen,
  input  logic [31:0] din,
  input  logic        req_pk,
  input  logic        req_c,
  output logic        ready_pk,
  output logic        ready_c,
  output logic        valid,
  output logic [31:0] dout,
  output logic        err,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    READY,
    DRAIN,
    ERR
  } state_t;

  state_t state, state_d;

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   cnt;
  logic [AW:0]   len;
  logic [8:0]    len9;
  logic [2:0]    k_q;
  logic          mtype_q;
  logic          k_ok;
  logic          wr;
  logic          rd;
  logic          drop;
  logic          go;

  assign k_ok = (k == 3'd2) || (k == 3'd3) || (k == 3'd4);
  assign busy = (state != IDLE);
  assign len  = (AW+1)'(len9);

  always_comb begin
    len9 = 9'd0;
    if (!mtype_q) begin
      len9 = 9'd96 * 9'(k_q) + 9'd8;
    end else begin
      unique case (1'b1)
        (k_q == 3'd4): len9 = 9'd392;
        (k_q == 3'd3): len9 = 9'd272;
        default:       len9 = 9'd192;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_d;
  end

  always_comb begin
    state_d = state;
    wr      = 1'b0;
    rd      = 1'b0;
    drop    = 1'b0;
    go      = 1'b0;
    if (start) begin
      state_d = k_ok ? FILL : ERR;
    end else begin
      unique case (state)
        IDLE: ;
        FILL: begin
          if (wen) begin
            wr = 1'b1;
            if (cnt + 1'b1 == len) state_d = READY;
          end
        end
        READY: begin
          drop = wen;
          go   = (req_pk && ready_pk) || (req_c && ready_c);
          if (go) state_d = DRAIN;
        end
        DRAIN: begin
          drop = wen;
          if ({1'b0, rptr} == len) state_d = IDLE;
          else                     rd      = 1'b1;
        end
        ERR: ;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wptr] <= din;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr     <= '0;
      rptr     <= '0;
      cnt      <= '0;
      k_q      <= '0;
      mtype_q  <= 1'b0;
      ready_pk <= 1'b0;
      ready_c  <= 1'b0;
      valid    <= 1'b0;
      dout     <= '0;
      err      <= 1'b0;
    end else if (start) begin
      wptr     <= '0;
      rptr     <= '0;
      cnt      <= '0;
      k_q      <= k;
      mtype_q  <= msg_type;
      ready_pk <= 1'b0;
      ready_c  <= 1'b0;
      valid    <= 1'b0;
      err      <= !k_ok;
    end else begin
      if (wr) begin
        wptr <= wptr + 1'b1;
        cnt  <= cnt + 1'b1;
        if (state_d == READY) begin
          ready_pk <= !mtype_q;
          ready_c  <= mtype_q;
        end
      end
      if (drop) err <= 1'b1;
      if (go) begin
        ready_pk <= 1'b0;
        ready_c  <= 1'b0;
        rptr     <= '0;
      end
      valid <= rd;
      if (rd) begin
        dout <= mem[rptr];
        rptr <= rptr + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_kyber_link_buffer.sv
// tb_kyber_link_buffer: directed + random frames against a queue model.
// Expected lengths come from the frame-size rules; data from a word queue.
module tb_kyber_link_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  k = 3'd0;
  logic        msg_type = 1'b0;
  logic        wen = 1'b0;
  logic [31:0] din = '0;
  logic        req_pk = 1'b0;
  logic        req_c = 1'b0;
  logic        ready_pk;
  logic        ready_c;
  logic        valid;
  logic [31:0] dout;
  logic        err;
  logic        busy;

  int          n_assert = 0;
  int          n_fail = 0;
  logic [31:0] q[$];
  int          exp_len = 0;
  logic        exp_err = 1'b0;

  kyber_link_buffer #(.DEPTH(512), .AW(9)) dut (
    .clk(clk), .rst(rst), .start(start), .k(k),
    .msg_type(msg_type), .wen(wen), .din(din),
    .req_pk(req_pk), .req_c(req_c),
    .ready_pk(ready_pk), .ready_c(ready_c),
    .valid(valid), .dout(dout), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int frame_len(input int kk, input bit mt);
    if (!mt) return 96 * kk + 8;
    case (kk)
      2:       return 192;
      3:       return 272;
      default: return 392;
    endcase
  endfunction

  task automatic start_frame(input int kk, input bit mt);
    start = 1'b1;
    k = 3'(kk);
    msg_type = mt;
    tick();
    start = 1'b0;
    q.delete();
    exp_len = frame_len(kk, mt);
    exp_err = !(kk >= 2 && kk <= 4);
  endtask

  task automatic fill(input int n, input bit gaps, input bit seq);
    int early;
    early = 0;
    for (int i = 0; i < n; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) tick();
      wen = 1'b1;
      din = seq ? 32'(q.size()) : $urandom;
      q.push_back(din);
      tick();
      wen = 1'b0;
      if (i < n - 1 && (ready_pk || ready_c)) early++;
    end
    chk("fill_no_early_ready", 32'(early), 32'd0);
  endtask

  task automatic drain(input bit mt, input int stop_at, input bit inject);
    if (mt) req_c = 1'b1;
    else    req_pk = 1'b1;
    tick();
    req_pk = 1'b0;
    req_c = 1'b0;
    chk("ready_fall", {30'd0, ready_pk, ready_c}, 32'd0);
    chk("valid_pre", 32'(valid), 32'd0);
    for (int i = 0; i < stop_at; i++) begin
      wen = inject && (i == 10);
      din = 32'hBAD0_BAD0;
      if (wen) exp_err = 1'b1;
      tick();
      wen = 1'b0;
      chk("drain_valid", 32'(valid), 32'd1);
      chk("drain_dout", dout, q[i]);
    end
    if (stop_at == exp_len) begin
      tick();
      chk("valid_end", 32'(valid), 32'd0);
      chk("busy_end", 32'(busy), 32'd0);
      chk("dout_hold", dout, q[exp_len-1]);
      chk("err_after_drain", 32'(err), 32'(exp_err));
    end
  endtask

  initial begin
    tick();
    chk("rst_ready_pk", 32'(ready_pk), 32'd0);
    chk("rst_ready_c", 32'(ready_c), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_dout", dout, 32'd0);
    rst = 1'b1;
    tick();

    // IDLE ignores wen and req
    wen = 1'b1;
    req_pk = 1'b1;
    repeat (3) tick();
    wen = 1'b0;
    req_pk = 1'b0;
    tick();
    chk("idle_err", 32'(err), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_valid", 32'(valid), 32'd0);

    // public key k=2, sequential data
    start_frame(2, 1'b0);
    chk("pk2_busy", 32'(busy), 32'd1);
    fill(exp_len, 1'b0, 1'b1);
    chk("pk2_ready_pk", 32'(ready_pk), 32'd1);
    chk("pk2_ready_c", 32'(ready_c), 32'd0);
    drain(1'b0, exp_len, 1'b0);

    // ciphertext k=4, sparse random input
    start_frame(4, 1'b1);
    fill(exp_len, 1'b1, 1'b0);
    chk("ct4_ready_c", 32'(ready_c), 32'd1);
    chk("ct4_ready_pk", 32'(ready_pk), 32'd0);
    drain(1'b1, exp_len, 1'b0);

    // wrong request, then overflow word
    start_frame(3, 1'b0);
    fill(exp_len, 1'b0, 1'b0);
    req_c = 1'b1;
    tick();
    req_c = 1'b0;
    tick();
    chk("wrongreq_ready_pk", 32'(ready_pk), 32'd1);
    chk("wrongreq_valid", 32'(valid), 32'd0);
    chk("wrongreq_err", 32'(err), 32'd0);
    wen = 1'b1;
    din = 32'hFFFF_0000;
    tick();
    wen = 1'b0;
    exp_err = 1'b1;
    chk("ovf_err", 32'(err), 32'd1);
    chk("ovf_ready_pk", 32'(ready_pk), 32'd1);
    drain(1'b0, exp_len, 1'b0);

    // illegal rank
    start_frame(5, 1'b0);
    chk("bad_k_err", 32'(err), 32'd1);
    chk("bad_k_busy", 32'(busy), 32'd1);
    wen = 1'b1;
    repeat (4) tick();
    wen = 1'b0;
    tick();
    chk("bad_k_ready", {30'd0, ready_pk, ready_c}, 32'd0);
    chk("bad_k_err_hold", 32'(err), 32'd1);
    start_frame(2, 1'b1);
    chk("recover_err", 32'(err), 32'd0);
    chk("recover_busy", 32'(busy), 32'd1);
    fill(exp_len, 1'b1, 1'b0);
    chk("recover_ready_c", 32'(ready_c), 32'd1);
    drain(1'b1, exp_len, 1'b0);

    // reset in the middle of a k=4 drain, with a dropped wen first
    start_frame(4, 1'b0);
    fill(exp_len, 1'b0, 1'b0);
    drain(1'b0, 50, 1'b1);
    chk("pre_rst_err", 32'(err), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("arst_valid", 32'(valid), 32'd0);
    chk("arst_ready", {30'd0, ready_pk, ready_c}, 32'd0);
    chk("arst_err", 32'(err), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    tick();
    rst = 1'b1;
    tick();
    start_frame(2, 1'b0);
    fill(exp_len, 1'b0, 1'b0);
    chk("post_rst_ready_pk", 32'(ready_pk), 32'd1);
    drain(1'b0, exp_len, 1'b0);

    // restart mid-fill with a wen in the start cycle
    start_frame(3, 1'b0);
    fill(100, 1'b0, 1'b0);
    wen = 1'b1;
    din = 32'hDEAD_BEEF;
    start_frame(3, 1'b0);
    wen = 1'b0;
    fill(exp_len - 1, 1'b0, 1'b0);
    chk("restart_not_ready", 32'(ready_pk), 32'd0);
    chk("restart_busy", 32'(busy), 32'd1);
    fill(1, 1'b0, 1'b0);
    chk("restart_ready", 32'(ready_pk), 32'd1);
    drain(1'b0, exp_len, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/kyber_link_buffer.md
Name: kyber_link_buffer

Overview:
- Store-and-forward message buffer on the 32-bit word link between the Kyber server and client.
- Captures one complete public-key or ciphertext frame from the upstream `valid`/`dout` stream (this block's `wen`/`din`).
- Announces completion on `ready_pk` or `ready_c`.
- Replays the frame back-to-back when the consumer raises the matching `req_pk` or `req_c`.
- Frame length is derived from the security parameter `k`.

Parameters:
- DEPTH, 512, word capacity of the internal buffer; must be ≥ 392 (largest frame).
- AW, 9, address width, log2(DEPTH).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset; asynchronous, active-low.
- start  in  1  one-cycle pulse; clears the buffer and latches `k` and `msg_type`.
- k  in  3  Kyber module rank; legal values 2, 3, 4.
- msg_type  in  1  frame type; 0 = public key, 1 = ciphertext.
- wen  in  1  input word strobe.
- din  in  32  input word.
- req_pk  in  1  consumer request to drain a public-key frame.
- req_c  in  1  consumer request to drain a ciphertext frame.
- ready_pk  out  1  complete public-key frame held.
- ready_c  out  1  complete ciphertext frame held.
- valid  out  1  output word strobe.
- dout  out  32  output word.
- err  out  1  sticky error flag.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (`rst` = 0, any state, including mid-fill or mid-drain):
  - state ← IDLE; write/read pointers and word counter ← 0.
  - `ready_pk`, `ready_c`, `valid`, `err`, `busy` ← 0; `dout` ← 0.
  - Buffer contents are don't-care.
- Frame length LEN, latched at `start`:
  - Public key: LEN = 96·k + 8, giving 200 / 296 / 392 words for k = 2 / 3 / 4.
  - Ciphertext: LEN = 192 / 272 / 392 words for k = 2 / 3 / 4.
  - Computed in 9-bit arithmetic; no truncation for legal `k`.
- States: IDLE, FILL, READY, DRAIN, ERR.
- `start` has priority in every state:
  - Clears pointers, counter, `err`, `ready_*` and `valid`.
  - Latches `k` and `msg_type`.
  - Next state is FILL if `k` ∈ {2, 3, 4}, else ERR with `err` = 1.
  - A `wen` in the same cycle as `start` is discarded.
- IDLE:
  - `wen` is ignored, with no error.
  - `req_*` is ignored.
- FILL:
  - Each `wen` writes `din` at the write pointer; pointer and counter increment.
  - On the edge that writes word LEN, next state is READY.
  - `ready_pk` (msg_type = 0) or `ready_c` (msg_type = 1) is registered high from the following cycle.
  - `req_*` in FILL is ignored.
- READY:
  - The asserted `ready_*` holds until the matching request is sampled.
  - `req_pk` while `ready_c` is high, or `req_c` while `ready_pk` is high, is ignored.
  - `wen` is dropped and sets `err`.
  - Matching request sampled at edge N:
    - `ready_*` falls after edge N.
    - State → DRAIN; read pointer ← 0.
- DRAIN:
  - Synchronous buffer read with 1-cycle latency.
  - `valid` is high for exactly LEN consecutive cycles, N+2 through N+LEN+1.
  - `dout` carries words in write order, with `dout` stable and correct whenever `valid` = 1.
  - No gaps and no backpressure.
  - After the last word, `valid` falls and state → IDLE.
  - `wen` during DRAIN is dropped and sets `err`; the drain continues unaffected.
  - `req_*` in DRAIN is ignored.
- ERR:
  - All inputs except `start` and `rst` are ignored.
  - `err` stays high.
- `err` is sticky: cleared only by `start` or reset.
- `dout` holds its last value while `valid` = 0.
- Write-pointer wrap cannot occur for legal LEN. The counter saturates at LEN; any write beyond LEN is treated as a READY-state write.

Test Plan:
- Public key, k = 2:
  - Stimulus: `start` with k = 2, msg_type = 0; 200 `wen` words 0x0000_0000..0x0000_00C7, one per cycle.
  - Response: `ready_pk` = 1 the cycle after the 200th write; `ready_c` stays 0.
  - Then `req_pk` at edge N → `valid` high cycles N+2..N+201 with `dout` = 0x00..0xC7 in order; `ready_pk` low from N+1.
- Ciphertext, k = 4, sparse input:
  - Stimulus: `start` with k = 4, msg_type = 1; 392 words with random `wen` gaps.
  - Response: `ready_c` only after word 392; drain yields 392 contiguous words matching input; `busy` = 0 afterwards.
- Wrong request and overflow:
  - Stimulus: k = 3 public key completes (296 words); assert `req_c`; then one extra `wen`.
  - Response: `req_c` ignored and `ready_pk` stays 1; extra word sets `err` = 1; subsequent `req_pk` still drains exactly 296 correct words.
- Illegal rank:
  - Stimulus: `start` with k = 5.
  - Response: `err` = 1, `busy` = 1, no `ready_*`, `wen` ignored.
  - Then `start` with k = 2 clears `err` and enters FILL.
- Reset mid-drain:
  - Stimulus: assert `rst` = 0 asynchronously 50 words into a k = 4 drain.
  - Response: `valid`, `ready_*`, `err`, `busy` drop immediately.
  - After release, a fresh k = 2 frame fills and drains correctly.
- Restart mid-fill:
  - Stimulus: `start` after 100 of 296 words, with `wen` in the same cycle.
  - Response: that word is discarded; a complete new frame is required before `ready_*` asserts.
